// File: rtl/trivium_load_ctrl.sv
// Byte-stream command parser feeding the Trivium core: assembles key/IV
// frames in a shadow register, commits them whole, and runs the start handshake.
module trivium_load_ctrl #(
  parameter int CLK_FREQ      = 100000000,
  parameter int BAUD_RATE     = 9600,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        start_ack,
  output logic [79:0] key,
  output logic [79:0] iv,
  output logic        key_valid,
  output logic        iv_valid,
  output logic        start_req,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam longint unsigned TERM_L =
    (longint'(TIMEOUT_BYTES) * 64'd10 * longint'(CLK_FREQ))
    / longint'(BAUD_RATE);
  localparam int CW = $clog2(TERM_L + 1);
  localparam logic [CW-1:0] TERM = CW'(TERM_L);

  localparam logic [7:0] CMD_KEY   = 8'h4B;
  localparam logic [7:0] CMD_IV    = 8'h49;
  localparam logic [7:0] CMD_START = 8'h53;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    KEY        = 2'd1,
    IV         = 2'd2,
    START_WAIT = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [79:0]    shadow;
  logic [3:0]     byte_cnt;
  logic [CW-1:0]  tcnt;

  logic           shift;
  logic           commit_key;
  logic           commit_iv;
  logic           cnt_clr;
  logic           start_set;
  logic           start_clr;
  logic           err_n;
  logic [1:0]     code_n;
  logic [79:0]    frame;

  assign frame = {shadow[71:0], rx_data};
  assign busy  = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and control decode
  always_comb begin
    state_n    = state;
    shift      = 1'b0;
    commit_key = 1'b0;
    commit_iv  = 1'b0;
    cnt_clr    = 1'b1;
    start_set  = 1'b0;
    start_clr  = 1'b0;
    err_n      = 1'b0;
    code_n     = err_code;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_KEY: state_n = KEY;
            CMD_IV:  state_n = IV;
            CMD_START: begin
              if (key_valid && iv_valid) begin
                state_n   = START_WAIT;
                start_set = 1'b1;
              end else begin
                err_n  = 1'b1;
                code_n = 2'd3;
              end
            end
            default: begin
              err_n  = 1'b1;
              code_n = 2'd1;
            end
          endcase
        end
      end
      KEY, IV: begin
        if (rx_valid) begin
          shift = 1'b1;
          if (byte_cnt == 4'd9) begin
            commit_key = (state == KEY);
            commit_iv  = (state == IV);
            state_n    = IDLE;
          end
        end else if (tcnt == TERM) begin
          err_n   = 1'b1;
          code_n  = 2'd2;
          state_n = IDLE;
        end else begin
          cnt_clr = 1'b0;
        end
      end
      START_WAIT: begin
        if (start_ack) begin
          start_clr = 1'b1;
          state_n   = IDLE;
        end
        if (rx_valid) begin
          err_n  = 1'b1;
          code_n = 2'd3;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Shadow assembly, byte counter and inter-byte timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      byte_cnt <= '0;
      tcnt     <= '0;
    end else begin
      if (shift) shadow <= frame;
      if (shift)              byte_cnt <= byte_cnt + 4'd1;
      else if (state == IDLE) byte_cnt <= '0;
      if (cnt_clr) tcnt <= '0;
      else         tcnt <= tcnt + 1'b1;
    end
  end

  // Committed key/IV and their valid flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key       <= '0;
      iv        <= '0;
      key_valid <= 1'b0;
      iv_valid  <= 1'b0;
    end else begin
      if (commit_key) begin
        key       <= frame;
        key_valid <= 1'b1;
      end
      if (commit_iv) begin
        iv       <= frame;
        iv_valid <= 1'b1;
      end else if (start_clr) begin
        iv_valid <= 1'b0;
      end
    end
  end

  // Start request and error reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_req <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      if (start_set)      start_req <= 1'b1;
      else if (start_clr) start_req <= 1'b0;
      err      <= err_n;
      err_code <= code_n;
    end
  end

endmodule

// File: tb/tb_trivium_load_ctrl.sv
// Directed bench for trivium_load_ctrl: a per-cycle vector table plus
// hand sequences for timeouts, boundary timing and reset.
module tb_trivium_load_ctrl;

  localparam int TERM = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        start_ack = 1'b0;
  logic [79:0] key, iv;
  logic        key_valid, iv_valid, start_req, busy, err;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;

  trivium_load_ctrl #(
    .CLK_FREQ(9600), .BAUD_RATE(9600), .TIMEOUT_BYTES(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .start_ack(start_ack), .key(key), .iv(iv), .key_valid(key_valid),
    .iv_valid(iv_valid), .start_req(start_req), .busy(busy),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       a;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic v, logic [7:0] d, logic a,
                              logic kv, logic ivv, logic sr, logic bz,
                              logic er, logic [1:0] ec);
    vec_t t;
    t.v = v; t.d = d; t.a = a;
    t.exp = {kv, ivv, sr, bz, er, ec};
    tbl.push_back(t);
  endfunction

  task automatic chk(string nm, logic [79:0] act, logic [79:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic cyc(logic v, logic [7:0] d, logic a);
    @(negedge clk);
    rx_valid = v; rx_data = d; start_ack = a;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rx_data = '0; start_ack = 1'b0;
  endtask

  function automatic logic [6:0] outs();
    return {key_valid, iv_valid, start_req, busy, err, err_code};
  endfunction

  initial begin
    int i;
    logic seen;

    // kv ivv sr bz er ec
    add(1, 8'h53, 0, 0, 0, 0, 0, 1, 2'd3);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 2'd3);
    add(1, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1);
    add(1, 8'h4B, 0, 0, 0, 0, 1, 0, 2'd1);
    for (int b = 1; b <= 9; b++)
      add(1, 8'(b), 0, 0, 0, 0, 1, 0, 2'd1);
    add(1, 8'h0A, 0, 1, 0, 0, 0, 0, 2'd1);
    add(1, 8'h53, 0, 1, 0, 0, 0, 1, 2'd3);
    add(1, 8'h49, 0, 1, 0, 0, 1, 0, 2'd3);
    for (int b = 0; b < 9; b++)
      add(1, 8'hF0 + 8'(b), 0, 1, 0, 0, 1, 0, 2'd3);
    add(1, 8'hF9, 0, 1, 1, 0, 0, 0, 2'd3);
    add(1, 8'h53, 0, 1, 1, 1, 1, 0, 2'd3);
    add(0, 8'h00, 0, 1, 1, 1, 1, 0, 2'd3);
    add(0, 8'h00, 0, 1, 1, 1, 1, 0, 2'd3);
    add(1, 8'h4B, 0, 1, 1, 1, 1, 1, 2'd3);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 2'd3);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {73'd0, outs()}, 80'd0);
    chk("reset_key", key, 80'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) begin
      cyc(tbl[k].v, tbl[k].d, tbl[k].a);
      chk($sformatf("vec%0d", k), {73'd0, outs()}, {73'd0, tbl[k].exp});
    end
    chk("key_a", key, 80'h0102030405060708090A);
    chk("iv_a", iv, 80'hF0F1F2F3F4F5F6F7F8F9);

    // partial IV frame abandoned by timeout
    cyc(1, 8'h49, 0);
    for (int b = 0; b < 4; b++) cyc(1, 8'h11 + 8'(b), 0);
    i = TERM + 6;
    for (int c = 1; c <= TERM + 5; c++) begin
      cyc(0, 8'h00, 0);
      if (err) begin
        i = c;
        break;
      end
    end
    chk("to_latency", 80'(i), 80'(TERM + 1));
    chk("to_code", 80'(err_code), 80'd2);
    chk("to_busy", 80'(busy), 80'd0);
    chk("to_iv", iv, 80'hF0F1F2F3F4F5F6F7F8F9);
    chk("to_ivv", 80'(iv_valid), 80'd0);
    cyc(1, 8'h49, 0);
    for (int b = 0; b < 10; b++) cyc(1, 8'hA0 + 8'(b), 0);
    chk("iv_b", iv, 80'hA0A1A2A3A4A5A6A7A8A9);
    chk("iv_b_valid", 80'(iv_valid), 80'd1);

    // ack already present on start_req's first cycle
    cyc(1, 8'h53, 0);
    chk("sr_rise", 80'(start_req), 80'd1);
    cyc(0, 8'h00, 1);
    chk("sr_fast_drop", {77'd0, start_req, iv_valid, key_valid}, 80'd1);

    // bytes landing exactly on the timeout terminal count
    seen = 1'b0;
    cyc(1, 8'h4B, 0);
    cyc(1, 8'h31, 0);
    for (int c = 0; c < TERM; c++) begin
      cyc(0, 8'h00, 0);
      seen |= err;
    end
    cyc(1, 8'h32, 0);
    seen |= err;
    chk("edge_busy", 80'(busy), 80'd1);
    for (int b = 3; b <= 9; b++) cyc(1, 8'h30 + 8'(b), 0);
    for (int c = 0; c < TERM; c++) begin
      cyc(0, 8'h00, 0);
      seen |= err;
    end
    cyc(1, 8'h3A, 0);
    seen |= err;
    chk("edge_no_err", 80'(seen), 80'd0);
    chk("edge_key", key, 80'h3132333435363738393A);
    chk("edge_commit", {78'd0, key_valid, busy}, 80'd2);

    // asynchronous reset in the middle of a key frame
    cyc(1, 8'h4B, 0);
    for (int b = 0; b < 6; b++) cyc(1, 8'h41 + 8'(b), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_key", key, 80'd0);
    chk("rst_iv", iv, 80'd0);
    chk("rst_outs", {73'd0, outs()}, 80'd0);
    @(posedge clk);
    #1;
    chk("rst_no_err", 80'(err), 80'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 8'h4B, 0);
    for (int b = 0; b < 10; b++) cyc(1, 8'h51 + 8'(b), 0);
    chk("post_rst_key", key, 80'h5152535455565758595A);
    chk("post_rst_kv", {78'd0, key_valid, busy}, 80'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trivium_load_ctrl.md
# trivium_load_ctrl

Command controller between the UART receiver and the Trivium core. It parses the received byte stream into key-load, IV-load and start commands. It assembles the 80-bit key and IV in shadow registers and commits them atomically. It then launches core initialisation over a req/ack handshake, enforcing inter-byte timeouts and command legality.

## Interface
- CLK_FREQ, 100000000, system clock frequency in Hz
- BAUD_RATE, 9600, UART baud rate; one byte time = 10*CLK_FREQ/BAUD_RATE clocks
- TIMEOUT_BYTES, 4, inter-byte timeout in byte times during payload reception

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte from UART receiver
- rx_valid  in  1  one-cycle strobe; rx_data valid in the same cycle
- start_ack  in  1  core accepts start request
- key  out  80  committed key; reset 0
- iv  out  80  committed IV; reset 0
- key_valid  out  1  key committed since reset; reset 0
- iv_valid  out  1  fresh IV committed since last start; reset 0
- start_req  out  1  core initialisation request; reset 0
- busy  out  1  high in any state other than IDLE; reset 0
- err  out  1  one-cycle error pulse; reset 0
- err_code  out  2  code of the most recent error, held until the next one; reset 0

## Operation
- States: IDLE, KEY, IV, START_WAIT. Reset forces IDLE from any state and clears shadow registers, byte counter and timeout counter.
- IDLE, rx_valid high:
  - 0x4B → KEY, byte count cleared.
  - 0x49 → IV, byte count cleared.
  - 0x53 with key_valid and iv_valid both high → START_WAIT, start_req raised.
  - 0x53 otherwise → stay IDLE; err pulse, err_code=3 (not ready).
  - Any other byte → stay IDLE; err pulse, err_code=1 (bad command).
- KEY/IV, each rx_valid: shift the byte into the shadow register MSB-first. The first payload byte lands in bits [79:72] and the tenth in [7:0]. Increment the byte count.
- KEY/IV commit: on the tenth byte, copy the shadow register to key (or iv), set key_valid (or iv_valid), and return to IDLE.
- KEY/IV timeout: the timeout counter resets on entry and on every rx_valid. It counts clocks otherwise. When it reaches TIMEOUT_BYTES*10*CLK_FREQ/BAUD_RATE:
  - return to IDLE; err pulse, err_code=2;
  - committed key/iv and the valid flags are unchanged (the partial frame is discarded).
- START_WAIT:
  - start_req held high; key and iv guaranteed stable.
  - When start_ack is sampled high: drop start_req, clear iv_valid (each start needs a fresh IV), return to IDLE. key_valid is retained.
  - Any rx_valid in START_WAIT: byte dropped, err pulse, err_code=3; state unchanged.
- No timeout in IDLE or START_WAIT.
- Counter width: enough bits to hold the timeout terminal count; byte counter 4 bits.

## Timing
- All outputs registered; no combinational path from input to output.
- State, commit and err all update on the clock edge after the rx_valid cycle that causes them:
  - key/key_valid (or iv/iv_valid) change 1 cycle after the tenth payload rx_valid.
  - start_req rises 1 cycle after the 0x53 rx_valid.
  - err is a pulse exactly 1 cycle wide; err_code updates on the same edge.
- start_req falls 1 cycle after start_ack is sampled high. start_ack already high on start_req's first cycle completes the handshake in one cycle.
- rx_valid and timeout terminal count in the same cycle: the byte wins. It is accepted, and the counter resets without error.
- Tenth byte and timeout in the same cycle: commit, no error.
- Back-to-back rx_valid on consecutive cycles are all accepted.
- Reset asserted mid-frame or mid-handshake: all outputs return to reset values asynchronously; no err pulse.

## Test plan
- Send 0x4B then bytes 0x01..0x0A → key=0x0102030405060708090A and key_valid=1 one cycle after the last byte; busy low after commit.
- Load key, send 0x49 then 0xF0..0xF9, then send 0x53 → start_req rises next cycle. Assert start_ack 3 cycles later → start_req low next cycle, iv_valid=0, key_valid=1.
- Send 0x53 after reset → no start_req; err pulse with err_code=3. Send 0x00 → err pulse with err_code=1.
- Send 0x49 and 4 payload bytes, then idle beyond the timeout → err pulse with err_code=2, state IDLE, iv and iv_valid unchanged. A following full IV frame commits correctly.
- During START_WAIT, send 0x4B → err with err_code=3, start_req still high, key unchanged.
- Assert rst after 6 key bytes → outputs zero immediately. A fresh 0x4B frame after reset loads correctly.
